// File: rtl/cache_bridge_pkg.sv
// Shared types and constants for the cache-to-SDRAM bridge.
package cache_bridge_pkg;

  localparam int unsigned BURST_LEN = 8;
  localparam int unsigned CNT_W     = $clog2(BURST_LEN);

  typedef logic [1:0] ben_t;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdCollect,
    StRdReplay,
    StWrReq,
    StWrHold
  } state_e;

endpackage

// File: rtl/fill_buffer.sv
// Flop-based line buffer: one write port, one combinational read port, no reset.
module fill_buffer
  import cache_bridge_pkg::*;
#(
  parameter int unsigned Depth = BURST_LEN,
  parameter int unsigned DataW = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(Depth)-1:0] wr_idx,
  input  logic [DataW-1:0]         wr_data,
  input  logic [$clog2(Depth)-1:0] rd_idx,
  output logic [DataW-1:0]         rd_data
);

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/cache_sdram_bridge.sv
// Bridge between the cache SDRAM port and the SDRAM controller: fill bursts are buffered
// and replayed gap-free. Define WRITE_POST_EN to acknowledge writes before sd_ack.
module cache_sdram_bridge
  import cache_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BURST_LEN = cache_bridge_pkg::BURST_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cache_req,
  input  logic              cache_rw,
  input  logic [ADDR_W-1:0] cache_addr,
  input  ben_t              cache_ben,
  input  logic [DATA_W-1:0] data_from_cache,
  output logic              cache_fill,
  output logic [DATA_W-1:0] data_to_cache,
  output logic              cache_wrack,
  output logic              sd_req,
  output logic              sd_rw,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_wdata,
  output ben_t              sd_ben,
  input  logic              sd_ack,
  input  logic              sd_dvalid,
  input  logic [DATA_W-1:0] sd_rdata
);

  localparam int unsigned CntW = $clog2(BURST_LEN);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   rep_q, rep_d;
  logic              sd_req_q, sd_req_d;
  logic              sd_rw_q, sd_rw_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic [DATA_W-1:0] sd_wdata_q, sd_wdata_d;
  ben_t              sd_ben_q, sd_ben_d;
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wrack_q, wrack_d;
  logic              buf_we;
  logic [DATA_W-1:0] buf_rdata;
`ifdef WRITE_POST_EN
  logic              ack_seen_q, ack_seen_d;
`endif

  fill_buffer #(
    .Depth (BURST_LEN),
    .DataW (DATA_W)
  ) u_fill_buffer (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_idx  (cnt_q),
    .wr_data (sd_rdata),
    .rd_idx  (rep_q),
    .rd_data (buf_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    sd_req_d   = sd_req_q;
    sd_rw_d    = sd_rw_q;
    sd_addr_d  = sd_addr_q;
    sd_wdata_d = sd_wdata_q;
    sd_ben_d   = sd_ben_q;
    fill_d     = 1'b0;
    data_d     = data_q;
    wrack_d    = wrack_q;
    buf_we     = 1'b0;
`ifdef WRITE_POST_EN
    ack_seen_d = ack_seen_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cache_req) begin
          sd_addr_d  = cache_addr;
          sd_wdata_d = data_from_cache;
          sd_ben_d   = cache_ben;
          sd_req_d   = 1'b1;
          sd_rw_d    = cache_rw;
          cnt_d      = '0;
          state_d    = cache_rw ? StRdReq : StWrReq;
`ifdef WRITE_POST_EN
          wrack_d    = ~cache_rw;
          ack_seen_d = 1'b0;
`endif
        end
      end
      StRdReq, StRdCollect: begin
        if (state_q == StRdReq && sd_ack) begin
          sd_req_d = 1'b0;
          state_d  = StRdCollect;
        end
        if (sd_dvalid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(BURST_LEN - 1)) begin
            // Word 0 was written long ago, so it can be presented with the strobe.
            sd_req_d = 1'b0;
            fill_d   = 1'b1;
            data_d   = buf_rdata;
            rep_d    = CntW'(1);
            state_d  = StRdReplay;
          end
        end
      end
      StRdReplay: begin
        if (rep_q == '0) begin
          state_d = StIdle;
        end else begin
          data_d = buf_rdata;
          rep_d  = rep_q + CntW'(1);
        end
      end
`ifdef WRITE_POST_EN
      StWrReq: begin
        wrack_d = cache_req;
        if (sd_ack) begin
          sd_req_d   = 1'b0;
          ack_seen_d = 1'b1;
        end
        if ((ack_seen_q || sd_ack) && !cache_req) begin
          state_d = StWrHold;
        end
      end
`else
      StWrReq: begin
        if (sd_ack) begin
          sd_req_d = 1'b0;
          wrack_d  = 1'b1;
          state_d  = StWrHold;
        end
      end
`endif
      StWrHold: begin
        wrack_d = cache_req;
        if (!cache_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rep_q      <= '0;
      sd_req_q   <= 1'b0;
      sd_rw_q    <= 1'b1;
      sd_addr_q  <= '0;
      sd_wdata_q <= '0;
      sd_ben_q   <= '0;
      fill_q     <= 1'b0;
      data_q     <= '0;
      wrack_q    <= 1'b0;
`ifdef WRITE_POST_EN
      ack_seen_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      sd_req_q   <= sd_req_d;
      sd_rw_q    <= sd_rw_d;
      sd_addr_q  <= sd_addr_d;
      sd_wdata_q <= sd_wdata_d;
      sd_ben_q   <= sd_ben_d;
      fill_q     <= fill_d;
      data_q     <= data_d;
      wrack_q    <= wrack_d;
`ifdef WRITE_POST_EN
      ack_seen_q <= ack_seen_d;
`endif
    end
  end

  assign cache_fill    = fill_q;
  assign data_to_cache = data_q;
  assign cache_wrack   = wrack_q;
  assign sd_req        = sd_req_q;
  assign sd_rw         = sd_rw_q;
  assign sd_addr       = sd_addr_q;
  assign sd_wdata      = sd_wdata_q;
  assign sd_ben        = sd_ben_q;

endmodule

// File: tb/tb_cache_sdram_bridge.sv
// Directed bench for cache_sdram_bridge (default build, WRITE_POST_EN undefined).
module tb_cache_sdram_bridge;

  logic        clk;
  logic        reset;
  logic        cache_req;
  logic        cache_rw;
  logic [24:0] cache_addr;
  logic [1:0]  cache_ben;
  logic [15:0] data_from_cache;
  logic        cache_fill;
  logic [15:0] data_to_cache;
  logic        cache_wrack;
  logic        sd_req;
  logic        sd_rw;
  logic [24:0] sd_addr;
  logic [15:0] sd_wdata;
  logic [1:0]  sd_ben;
  logic        sd_ack;
  logic        sd_dvalid;
  logic [15:0] sd_rdata;

  int checks;
  int errors;

  cache_sdram_bridge dut (
    .clk             (clk),
    .reset           (reset),
    .cache_req       (cache_req),
    .cache_rw        (cache_rw),
    .cache_addr      (cache_addr),
    .cache_ben       (cache_ben),
    .data_from_cache (data_from_cache),
    .cache_fill      (cache_fill),
    .data_to_cache   (data_to_cache),
    .cache_wrack     (cache_wrack),
    .sd_req          (sd_req),
    .sd_rw           (sd_rw),
    .sd_addr         (sd_addr),
    .sd_wdata        (sd_wdata),
    .sd_ben          (sd_ben),
    .sd_ack          (sd_ack),
    .sd_dvalid       (sd_dvalid),
    .sd_rdata        (sd_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (cache_fill !== 1'b0) begin errors++; $display("FAIL reset_fill: got %b want 0", cache_fill); end
    checks++; if (data_to_cache !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", data_to_cache); end
    checks++; if (cache_wrack !== 1'b0) begin errors++; $display("FAIL reset_wrack: got %b want 0", cache_wrack); end
    checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL reset_sd_req: got %b want 0", sd_req); end
    checks++; if (sd_rw !== 1'b1) begin errors++; $display("FAIL reset_sd_rw: got %b want 1", sd_rw); end
    checks++; if (sd_addr !== 25'h0) begin errors++; $display("FAIL reset_sd_addr: got %h want 0", sd_addr); end
    checks++; if (sd_wdata !== 16'h0) begin errors++; $display("FAIL reset_sd_wdata: got %h want 0", sd_wdata); end
    checks++; if (sd_ben !== 2'b00) begin errors++; $display("FAIL reset_sd_ben: got %b want 00", sd_ben); end
    reset = 1'b1;
    tick();
    checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL idle_sd_req: got %b want 0", sd_req); end
  endtask

  // Gapless burst; the first word arrives together with sd_ack.
  task automatic test_gapless();
    logic [15:0] w [8];
    w = '{16'hA3, 16'hA4, 16'hA5, 16'hA6, 16'hA7, 16'hA0, 16'hA1, 16'hA2};
    cache_req = 1'b1; cache_rw = 1'b1; cache_addr = 25'h000013;
    tick();
    checks++; if (sd_req !== 1'b1) begin errors++; $display("FAIL rd_sd_req_rise: got %b want 1", sd_req); end
    checks++; if (sd_rw !== 1'b1) begin errors++; $display("FAIL rd_sd_rw: got %b want 1", sd_rw); end
    checks++; if (sd_addr !== 25'h000013) begin errors++; $display("FAIL rd_sd_addr: got %h want 000013", sd_addr); end
    cache_req = 1'b0;
    sd_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sd_dvalid = 1'b1; sd_rdata = w[i];
      tick();
      sd_ack = 1'b0;
      if (i == 0) begin
        checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL rd_sd_req_drop: got %b want 0", sd_req); end
      end
      if (i < 7) begin
        checks++; if (cache_fill !== 1'b0) begin errors++; $display("FAIL gl_early_fill word %0d: got %b want 0", i, cache_fill); end
      end
    end
    sd_dvalid = 1'b0;
    checks++; if (cache_fill !== 1'b1) begin errors++; $display("FAIL gl_fill: got %b want 1", cache_fill); end
    checks++; if (data_to_cache !== w[0]) begin errors++; $display("FAIL gl_data 0: got %h want %h", data_to_cache, w[0]); end
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++; if (data_to_cache !== w[k]) begin errors++; $display("FAIL gl_data %0d: got %h want %h", k, data_to_cache, w[k]); end
      checks++; if (cache_fill !== 1'b0) begin errors++; $display("FAIL gl_fill_extra %0d: got %b want 0", k, cache_fill); end
    end
    tick();
    checks++; if (cache_fill !== 1'b0) begin errors++; $display("FAIL gl_fill_after: got %b want 0", cache_fill); end
  endtask

  task automatic test_write();
    cache_req = 1'b1; cache_rw = 1'b0; cache_addr = 25'h00ABCD;
    data_from_cache = 16'h1234; cache_ben = 2'b01;
    tick();
    checks++; if (sd_req !== 1'b1) begin errors++; $display("FAIL wr_sd_req: got %b want 1", sd_req); end
    checks++; if (sd_rw !== 1'b0) begin errors++; $display("FAIL wr_sd_rw: got %b want 0", sd_rw); end
    checks++; if (sd_wdata !== 16'h1234) begin errors++; $display("FAIL wr_sd_wdata: got %h want 1234", sd_wdata); end
    checks++; if (sd_ben !== 2'b01) begin errors++; $display("FAIL wr_sd_ben: got %b want 01", sd_ben); end
    checks++; if (sd_addr !== 25'h00ABCD) begin errors++; $display("FAIL wr_sd_addr: got %h want 00abcd", sd_addr); end
    tick();
    tick();
    checks++; if (cache_wrack !== 1'b0) begin errors++; $display("FAIL wr_early_ack: got %b want 0", cache_wrack); end
    checks++; if (sd_req !== 1'b1) begin errors++; $display("FAIL wr_sd_req_hold: got %b want 1", sd_req); end
    data_from_cache = 16'hFFFF; cache_ben = 2'b11;
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    checks++; if (cache_wrack !== 1'b1) begin errors++; $display("FAIL wr_ack_rise: got %b want 1", cache_wrack); end
    checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL wr_sd_req_drop: got %b want 0", sd_req); end
    checks++; if (sd_wdata !== 16'h1234) begin errors++; $display("FAIL wr_wdata_latched: got %h want 1234", sd_wdata); end
    tick();
    checks++; if (cache_wrack !== 1'b1) begin errors++; $display("FAIL wr_ack_level: got %b want 1", cache_wrack); end
    cache_req = 1'b0;
    tick();
    checks++; if (cache_wrack !== 1'b0) begin errors++; $display("FAIL wr_ack_fall: got %b want 0", cache_wrack); end
    tick();
    checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL wr_idle_sd_req: got %b want 0", sd_req); end
  endtask

  // Two idle cycles between words; replay must still be contiguous.
  task automatic test_gapped();
    logic [15:0] w [8];
    w = '{16'hB3, 16'hB4, 16'hB5, 16'hB6, 16'hB7, 16'hB0, 16'hB1, 16'hB2};
    cache_req = 1'b1; cache_rw = 1'b1; cache_addr = 25'h000013;
    tick();
    checks++; if (sd_rw !== 1'b1) begin errors++; $display("FAIL gp_sd_rw: got %b want 1", sd_rw); end
    cache_req = 1'b0;
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sd_dvalid = 1'b1; sd_rdata = w[i];
      tick();
      sd_dvalid = 1'b0; sd_rdata = 16'hDEAD;
      if (i < 7) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          checks++; if (cache_fill !== 1'b0) begin errors++; $display("FAIL gp_early_fill word %0d: got %b want 0", i, cache_fill); end
        end
      end
    end
    checks++; if (cache_fill !== 1'b1) begin errors++; $display("FAIL gp_fill: got %b want 1", cache_fill); end
    checks++; if (data_to_cache !== w[0]) begin errors++; $display("FAIL gp_data 0: got %h want %h", data_to_cache, w[0]); end
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++; if (data_to_cache !== w[k]) begin errors++; $display("FAIL gp_data %0d: got %h want %h", k, data_to_cache, w[k]); end
      checks++; if (cache_fill !== 1'b0) begin errors++; $display("FAIL gp_fill_extra %0d: got %b want 0", k, cache_fill); end
    end
    tick();
  endtask

  // sd_dvalid held for 11 cycles: words 9..11 must be ignored.
  task automatic test_overrun();
    logic [15:0] w [8];
    w = '{16'hC5, 16'hC6, 16'hC7, 16'hC0, 16'hC1, 16'hC2, 16'hC3, 16'hC4};
    cache_req = 1'b1; cache_rw = 1'b1; cache_addr = 25'h000005;
    tick();
    cache_req = 1'b0;
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sd_dvalid = 1'b1; sd_rdata = w[i];
      tick();
    end
    sd_rdata = 16'hEEEE;
    checks++; if (cache_fill !== 1'b1) begin errors++; $display("FAIL ov_fill: got %b want 1", cache_fill); end
    checks++; if (data_to_cache !== w[0]) begin errors++; $display("FAIL ov_data 0: got %h want %h", data_to_cache, w[0]); end
    for (int k = 1; k < 8; k++) begin
      if (k == 4) sd_dvalid = 1'b0;
      tick();
      checks++; if (data_to_cache !== w[k]) begin errors++; $display("FAIL ov_data %0d: got %h want %h", k, data_to_cache, w[k]); end
      checks++; if (cache_fill !== 1'b0) begin errors++; $display("FAIL ov_second_fill %0d: got %b want 0", k, cache_fill); end
    end
    sd_dvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (cache_fill !== 1'b0) begin errors++; $display("FAIL ov_idle_fill %0d: got %b want 0", k, cache_fill); end
    end
    sd_dvalid = 1'b0;
    checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL ov_idle_sd_req: got %b want 0", sd_req); end
  endtask

  task automatic test_mid_reset();
    cache_req = 1'b1; cache_rw = 1'b1; cache_addr = 25'h000022;
    tick();
    cache_req = 1'b0;
    sd_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sd_dvalid = 1'b1; sd_rdata = 16'hD0 + 16'(i);
      tick();
      sd_ack = 1'b0;
    end
    reset = 1'b0;
    #1;
    checks++; if (sd_addr !== 25'h0) begin errors++; $display("FAIL mr_sd_addr: got %h want 0", sd_addr); end
    checks++; if (sd_rw !== 1'b1) begin errors++; $display("FAIL mr_sd_rw: got %b want 1", sd_rw); end
    checks++; if (data_to_cache !== 16'h0) begin errors++; $display("FAIL mr_data: got %h want 0000", data_to_cache); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sd_dvalid = 1'b1; sd_rdata = 16'hD4 + 16'(i);
      tick();
    end
    sd_dvalid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (cache_fill !== 1'b0) begin errors++; $display("FAIL mr_fill %0d: got %b want 0", k, cache_fill); end
    end
    checks++; if (sd_req !== 1'b0) begin errors++; $display("FAIL mr_sd_req: got %b want 0", sd_req); end
    checks++; if (data_to_cache !== 16'h0) begin errors++; $display("FAIL mr_data_after: got %h want 0000", data_to_cache); end
    // A fresh write is accepted one cycle later, so the machine sits in IDLE.
    cache_req = 1'b1; cache_rw = 1'b0; data_from_cache = 16'h5A5A; cache_ben = 2'b10;
    tick();
    checks++; if (sd_req !== 1'b1) begin errors++; $display("FAIL mr_idle_accept: got %b want 1", sd_req); end
    checks++; if (sd_rw !== 1'b0) begin errors++; $display("FAIL mr_idle_rw: got %b want 0", sd_rw); end
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    cache_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    cache_req = 1'b0;
    cache_rw = 1'b0;
    cache_addr = '0;
    cache_ben = '0;
    data_from_cache = '0;
    sd_ack = 1'b0;
    sd_dvalid = 1'b0;
    sd_rdata = '0;
    checks = 0;
    errors = 0;
    test_reset();
    test_gapless();
    test_write();
    test_gapped();
    test_overrun();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_sdram_bridge.md
# cache_sdram_bridge

Sits between the two-way cache's SDRAM-side port and the SDRAM controller. Issues cache line fill reads and CPU write-throughs. Buffers each 8-word fill burst, which the controller may deliver with gaps. Replays the burst to the cache as an unbroken 8-cycle stream, critical word first, because the cache samples its fill data on exactly 8 consecutive cycles after the fill strobe.

## Interface
Parameters:
- ADDR_W, 25: word-address width, carrying byte address bits 25:1.
- DATA_W, 16: data word width.
- BURST_LEN, 8: words per cache line; must be a power of two.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- cache_req  in  1  request from the cache/CPU side; held high until serviced.
- cache_rw  in  1  1 = line fill read, 0 = write.
- cache_addr  in  ADDR_W  word address; bits [2:0] select the critical word.
- cache_ben  in  2  write byte enables {upper, lower}, active-high.
- data_from_cache  in  DATA_W  write data.
- cache_fill  out  1  one-cycle strobe marking replay word 0.
- data_to_cache  out  DATA_W  replay data.
- cache_wrack  out  1  write acknowledge; a level signal.
- sd_req  out  1  request to the SDRAM controller.
- sd_rw  out  1  1 = read burst, 0 = single-word write.
- sd_addr  out  ADDR_W  latched request address.
- sd_wdata  out  DATA_W  latched write data.
- sd_ben  out  2  latched byte enables.
- sd_ack  in  1  controller accepted the request (reads) or completed it (writes).
- sd_dvalid  in  1  one read word valid this cycle.
- sd_rdata  in  DATA_W  read word, delivered critical-first with wrap.

## Operation
States: IDLE, RD_REQ, RD_COLLECT, RD_REPLAY, WR_REQ, WR_HOLD.

- **IDLE**
  - On cache_req=1, latch cache_addr, cache_ben and data_from_cache into sd_addr, sd_ben and sd_wdata.
  - cache_rw=1 -> RD_REQ; cache_rw=0 -> WR_REQ.
  - sd_dvalid is ignored in IDLE; stray words arriving after a reset are discarded.
- **RD_REQ**
  - sd_req=1, sd_rw=1 until sd_ack, then -> RD_COLLECT.
  - sd_dvalid seen in the same cycle as sd_ack, or before it, is captured.
- **RD_COLLECT**
  - Each sd_dvalid stores sd_rdata at buf[cnt] and increments cnt (3-bit).
  - When the 8th word is stored -> RD_REPLAY.
  - Words arrive in wrapped order, so replay is in arrival order with no reindexing.
- **RD_REPLAY**
  - Cycle k (0..7): data_to_cache=buf[k]; cache_fill=1 only at k=0.
  - After k=7 -> IDLE.
  - cache_req is ignored while in RD_REPLAY.
- **WR_REQ**
  - sd_req=1, sd_rw=0 until sd_ack, then -> WR_HOLD.
- **WR_HOLD**
  - cache_wrack=1 while cache_req=1.
  - Return to IDLE on the first cycle cache_req=0.
- sd_dvalid pulses beyond BURST_LEN in one burst are ignored.
- cnt clears on entry to RD_REQ.

## Timing
- Reset values: cache_fill=0, data_to_cache=0, cache_wrack=0, sd_req=0, sd_rw=1, sd_addr=0, sd_wdata=0, sd_ben=0; state IDLE, cnt=0.
- All outputs are registered.
- Request latency: sd_req rises 1 cycle after cache_req is sampled in IDLE.
- sd_req drops the cycle after sd_ack.
- Fill latency: cache_fill is high the cycle after the 8th sd_dvalid. The 8 replay cycles are contiguous with no bubbles.
- Write acknowledge: cache_wrack rises the cycle after sd_ack.
- Reset asserted mid-burst: the machine returns to IDLE immediately and the buffer contents are don't-care. The controller is expected to be reset alongside.

## Configuration
WRITE_POST_EN controls posted writes.
- **Defined:**
  - In WR_REQ, cache_wrack rises 1 cycle after latch, independent of sd_ack, and stays high while cache_req=1.
  - sd_req stays high until sd_ack.
  - A new request in IDLE is stalled until the posted write's sd_ack has been seen.
  - State moves WR_REQ -> WR_HOLD only when both sd_ack has been seen and cache_req=0.
- **Undefined:** write acknowledge waits for sd_ack, as described above.

## Structure
- Package cache_bridge_pkg holds:
  - the state enum;
  - BURST_LEN, with CNT_W = log2(BURST_LEN);
  - a byte-enable type.
- Sub-module fill_buffer: BURST_LEN x DATA_W register file with one write port (wr_en, wr_idx, wr_data) and one read port (rd_idx -> rd_data). It is flop based and has no reset.
- The top level holds the FSM, the capture counter, the replay counter and the address/data latches.

## Test plan
- Gapless read: cache_addr=0x000013; 8 back-to-back sd_dvalid with data 0xA3..0xA7, 0xA0..0xA2 -> cache_fill one cycle after the last word; data_to_cache = 0xA3,0xA4,0xA5,0xA6,0xA7,0xA0,0xA1,0xA2 on 8 consecutive cycles.
- Gapped read: 2-cycle gaps between sd_dvalid pulses -> replay is still 8 contiguous cycles, identical ordering, one cache_fill pulse.
- Write: cache_rw=0, data 0x1234, ben=2'b01 -> sd_wdata=0x1234, sd_ben=01, sd_rw=0. cache_wrack rises the cycle after sd_ack (macro undefined), or 1 cycle after latch (WRITE_POST_EN), and falls after cache_req drops.
- Edge cases: sd_ack coincident with the first sd_dvalid -> word captured. A 9th sd_dvalid -> ignored, with no second cache_fill.
- Mid-burst reset: reset low after 4 words, then 4 more sd_dvalid -> all outputs at reset values, no cache_fill, state IDLE.
